sc_invader_stepper: RTL and testbench



---
 rtl/sc_invader_stepper.sv | 136 +++++++++++++
 tb/tb_sc_invader_stepper.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/sc_invader_stepper.sv
// rtl/sc_invader_stepper.sv - turns timer end-of-count ticks into invader formation sweep/drop/land steps.
// Optional SC_STEPPER_SPEEDUP_EN: each non-landing drop shortens the step period by one tick (floor 1).
module sc_invader_stepper #(
  parameter int X_W            = 10,
  parameter int Y_W            = 9,
  parameter int TICK_W         = 4,
  parameter int X_MIN          = 0,
  parameter int X_MAX          = 600,
  parameter int X_INIT         = 0,
  parameter int Y_INIT         = 32,
  parameter int Y_MAX          = 400,
  parameter int STEP_X         = 8,
  parameter int STEP_Y         = 16,
  parameter int TICKS_PER_STEP = 4
) (
  input  logic           SC_STEPPER_CLOCK_50,
  input  logic           SC_STEPPER_RESET_InHigh,
  input  logic           SC_STEPPER_tick_InLow,
  input  logic           SC_STEPPER_start_InHigh,
  input  logic           SC_STEPPER_run_InHigh,
  output logic           SC_STEPPER_timerCount_OutLow,
  output logic [X_W-1:0] SC_STEPPER_posX_Out,
  output logic [Y_W-1:0] SC_STEPPER_posY_Out,
  output logic           SC_STEPPER_dirLeft_Out,
  output logic           SC_STEPPER_step_OutHigh,
  output logic           SC_STEPPER_landed_OutHigh
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, LANDED} state_t;
  typedef logic [X_W:0] xw_t;
  typedef logic [Y_W:0] yw_t;

  logic clk, rst, tick, start, run;
  assign clk   = SC_STEPPER_CLOCK_50;
  assign rst   = SC_STEPPER_RESET_InHigh;
  assign tick  = SC_STEPPER_tick_InLow;
  assign start = SC_STEPPER_start_InHigh;
  assign run   = SC_STEPPER_run_InHigh;

  state_t            state, state_nxt;
  logic [X_W-1:0]    pos_x;
  logic [Y_W-1:0]    pos_y;
  logic              dir_left, step, landed, tick_prev;
  logic [TICK_W-1:0] tick_cnt, period;

  logic tick_acc, step_evt, right_ok, left_ok, drop, land;
  xw_t  x_right, x_left;
  yw_t  y_drop;

  // Bounds are evaluated one bit wider than the position so nothing wraps.
  always_comb begin
    tick_acc = (state == RUN) && tick_prev && !tick;
    step_evt = tick_acc && (tick_cnt == period - 1'b1) && !start;
    x_right  = {1'b0, pos_x} + xw_t'(STEP_X);
    x_left   = {1'b0, pos_x} - xw_t'(STEP_X);
    right_ok = x_right <= xw_t'(X_MAX);
    left_ok  = {1'b0, pos_x} >= xw_t'(X_MIN + STEP_X);
    drop     = step_evt && (dir_left ? !left_ok : !right_ok);
    y_drop   = {1'b0, pos_y} + yw_t'(STEP_Y);
    land     = drop && (y_drop >= yw_t'(Y_MAX));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = run ? RUN : PAUSE;
    end else begin
      case (state)
        RUN: begin
          if (land)      state_nxt = LANDED;
          else if (!run) state_nxt = PAUSE;
        end
        PAUSE:   if (run) state_nxt = RUN;
        default: state_nxt = state;
      endcase
    end
  end

  always_comb begin
    SC_STEPPER_timerCount_OutLow = (state != RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_x     <= X_W'(X_INIT);
      pos_y     <= Y_W'(Y_INIT);
      dir_left  <= 1'b0;
      step      <= 1'b0;
      landed    <= 1'b0;
      tick_cnt  <= '0;
      period    <= TICK_W'(TICKS_PER_STEP);
      tick_prev <= 1'b1;
    end else begin
      tick_prev <= tick;
      step      <= step_evt;
      if (start) begin
        pos_x    <= X_W'(X_INIT);
        pos_y    <= Y_W'(Y_INIT);
        dir_left <= 1'b0;
        landed   <= 1'b0;
        tick_cnt <= '0;
        period   <= TICK_W'(TICKS_PER_STEP);
      end else if (step_evt) begin
        tick_cnt <= '0;
        if (land) begin
          pos_y  <= Y_W'(Y_MAX);
          landed <= 1'b1;
        end else if (drop) begin
          pos_y    <= y_drop[Y_W-1:0];
          dir_left <= !dir_left;
`ifdef SC_STEPPER_SPEEDUP_EN
          if (period > TICK_W'(1)) period <= period - 1'b1;
`endif
        end else if (dir_left) begin
          pos_x <= x_left[X_W-1:0];
        end else begin
          pos_x <= x_right[X_W-1:0];
        end
      end else if (tick_acc) begin
        tick_cnt <= tick_cnt + 1'b1;
      end
    end
  end

  assign SC_STEPPER_posX_Out       = pos_x;
  assign SC_STEPPER_posY_Out       = pos_y;
  assign SC_STEPPER_dirLeft_Out    = dir_left;
  assign SC_STEPPER_step_OutHigh   = step;
  assign SC_STEPPER_landed_OutHigh = landed;

endmodule

// File: tb/tb_sc_invader_stepper.sv
// tb/tb_sc_invader_stepper.sv - directed table-driven bench for sc_invader_stepper.
module tb_sc_invader_stepper;

  logic clk = 1'b0;
  logic rst, tick, start, run;
  logic timer_cnt, dir, step, landed;
  logic [9:0] x;
  logic [8:0] y;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sc_invader_stepper #(
    .X_W(10), .Y_W(9), .TICK_W(4), .X_MIN(0), .X_MAX(20), .X_INIT(0),
    .Y_INIT(0), .Y_MAX(40), .STEP_X(8), .STEP_Y(16), .TICKS_PER_STEP(2)
  ) dut (
    .SC_STEPPER_CLOCK_50(clk),
    .SC_STEPPER_RESET_InHigh(rst),
    .SC_STEPPER_tick_InLow(tick),
    .SC_STEPPER_start_InHigh(start),
    .SC_STEPPER_run_InHigh(run),
    .SC_STEPPER_timerCount_OutLow(timer_cnt),
    .SC_STEPPER_posX_Out(x),
    .SC_STEPPER_posY_Out(y),
    .SC_STEPPER_dirLeft_Out(dir),
    .SC_STEPPER_step_OutHigh(step),
    .SC_STEPPER_landed_OutHigh(landed)
  );

  typedef struct {
    int ticks;
    int x;
    int y;
    int dir;
    int landed;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One accepted tick: low for one edge, then released. Returns step seen on the sampling edge.
  task automatic pulse(output logic s);
    tick = 1'b0;
    cyc();
    s = step;
    tick = 1'b1;
    cyc();
  endtask

  task automatic check_entry(input int i);
    chk($sformatf("step%0d_x", i), int'(x), tbl[i].x);
    chk($sformatf("step%0d_y", i), int'(y), tbl[i].y);
    chk($sformatf("step%0d_dir", i), int'(dir), tbl[i].dir);
    chk($sformatf("step%0d_landed", i), int'(landed), tbl[i].landed);
  endtask

  task automatic apply_entry(input int i);
    logic s;
    for (int k = 0; k < tbl[i].ticks; k++) begin
      tick = 1'b0;
      cyc();
      s = step;
      if (k == tbl[i].ticks - 1) begin
        chk($sformatf("step%0d_pulse", i), int'(s), 1);
        check_entry(i);
      end else begin
        chk($sformatf("step%0d_nopulse%0d", i, k), int'(s), 0);
      end
      tick = 1'b1;
      cyc();
      if (k == tbl[i].ticks - 1) chk($sformatf("step%0d_pulse_end", i), int'(step), 0);
    end
  endtask

  int slow_n, fast_n, step_seen;
  logic s;

  initial begin
    slow_n = 2;
`ifdef SC_STEPPER_SPEEDUP_EN
    fast_n = 1;
`else
    fast_n = 2;
`endif
    tbl[0] = '{slow_n,  8,  0, 0, 0};
    tbl[1] = '{slow_n, 16,  0, 0, 0};
    tbl[2] = '{slow_n, 16, 16, 1, 0};
    tbl[3] = '{fast_n,  8, 16, 1, 0};
    tbl[4] = '{fast_n,  0, 16, 1, 0};
    tbl[5] = '{fast_n,  0, 32, 0, 0};
    tbl[6] = '{fast_n,  8, 32, 0, 0};
    tbl[7] = '{fast_n, 16, 32, 0, 0};
    tbl[8] = '{fast_n, 16, 40, 0, 1};

    rst = 1'b1; tick = 1'b1; start = 1'b0; run = 1'b0;
    repeat (2) cyc();
    rst = 1'b0;
    cyc();
    chk("rst_x", int'(x), 0);
    chk("rst_y", int'(y), 0);
    chk("rst_dir", int'(dir), 0);
    chk("rst_landed", int'(landed), 0);
    chk("rst_step", int'(step), 0);
    chk("rst_timer", int'(timer_cnt), 1);

    pulse(s);
    chk("idle_tick_step", int'(s), 0);
    chk("idle_tick_x", int'(x), 0);

    run = 1'b1; start = 1'b1;
    cyc();
    start = 1'b0;
    chk("start_timer", int'(timer_cnt), 0);

    apply_entry(0);
    apply_entry(1);

    // Held-low tick counts once, then pause retains the count.
    tick = 1'b0;
    step_seen = 0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      if (step) step_seen++;
    end
    tick = 1'b1;
    cyc();
    chk("held_tick_steps", step_seen, 0);
    run = 1'b0;
    cyc();
    chk("pause_timer", int'(timer_cnt), 1);
    step_seen = 0;
    for (int k = 0; k < 3; k++) begin
      pulse(s);
      if (s) step_seen++;
    end
    chk("pause_steps", step_seen, 0);
    chk("pause_x", int'(x), 16);
    run = 1'b1;
    cyc();
    chk("resume_timer", int'(timer_cnt), 0);
    pulse(s);
    chk("retained_cnt_step", int'(s), 1);
    check_entry(2);

    for (int i = 3; i < 9; i++) apply_entry(i);

    chk("landed_timer", int'(timer_cnt), 1);
    step_seen = 0;
    for (int k = 0; k < 3; k++) begin
      pulse(s);
      if (s) step_seen++;
    end
    chk("landed_ignore_steps", step_seen, 0);
    chk("landed_hold_y", int'(y), 40);

    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("restart_y", int'(y), 0);
    chk("restart_x", int'(x), 0);
    chk("restart_landed", int'(landed), 0);
    chk("restart_timer", int'(timer_cnt), 0);

    // Counter at period-1, then start and a falling tick on the same edge.
    pulse(s);
    chk("pre_collide_step", int'(s), 0);
    tick = 1'b0; start = 1'b1;
    cyc();
    chk("collide_step", int'(step), 0);
    chk("collide_x", int'(x), 0);
    start = 1'b0; tick = 1'b1;
    cyc();
    pulse(s);
    chk("collide_cnt0_a", int'(s), 0);
    pulse(s);
    chk("collide_cnt0_b", int'(s), 1);
    chk("collide_after_x", int'(x), 8);

    // Asynchronous reset between edges.
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("async_x", int'(x), 0);
    chk("async_y", int'(y), 0);
    chk("async_dir", int'(dir), 0);
    chk("async_landed", int'(landed), 0);
    chk("async_timer", int'(timer_cnt), 1);
    cyc();
    rst = 1'b0;
    cyc();
    chk("post_rst_timer", int'(timer_cnt), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
